serial_byte_assembler: RTL and testbench

Serial-to-parallel receiver that accepts one bit per handshake on a valid/ready input, assembles `WIDTH` bits into a word, and presents the word on a valid/ready output. It also compares the word against a constant pattern and flags a match. It is the collecting counterpart of the constant-bus bit-select exercises: those blocks pick single bits out of a bus, and this block builds the bus back up from single bits. It sits between a serial bit source (a testbench driver or a bit-select block) and any word-wide consumer.

---
 rtl/serial_byte_assembler.sv | 88 ++++++++
 tb/tb_serial_byte_assembler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_assembler.sv
// Serial-to-parallel receiver: collects WIDTH bits over a valid/ready input,
// presents the word over a valid/ready output and flags a constant-pattern match.
module serial_byte_assembler #(
   parameter int unsigned      WIDTH         = 8,
   parameter bit               MSB_FIRST     = 1'b1,
   parameter logic [WIDTH-1:0] MATCH_PATTERN = WIDTH'(8'hAF)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             bit_i,
   input  logic             bit_valid_i,
   output logic             bit_ready_o,
   input  logic             clear_i,
   output logic [WIDTH-1:0] data_o,
   output logic             data_valid_o,
   input  logic             data_ready_i,
   output logic             match_o
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_shift;
   logic             valid_q;
   logic             match_q;

   // Shift register contents after accepting bit_i in the configured order
   always_comb begin
      sh_shift = sh;
      if (MSB_FIRST) sh_shift = {sh[WIDTH-2:0], bit_i};
      else           sh_shift = {bit_i, sh[WIDTH-1:1]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= COLLECT;
         cnt     <= '0;
         sh      <= '0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else if (clear_i) begin
         state   <= COLLECT;
         cnt     <= '0;
         sh      <= '0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (bit_valid_i) begin
                  sh <= sh_shift;
                  if (cnt == LAST_CNT) begin
                     cnt     <= '0;
                     state   <= HOLD;
                     valid_q <= 1'b1;
                     match_q <= (sh_shift == MATCH_PATTERN);
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // Word is frozen until the consumer takes it
               if (data_ready_i) begin
                  state   <= COLLECT;
                  valid_q <= 1'b0;
                  match_q <= 1'b0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

   assign bit_ready_o  = (state == COLLECT);
   assign data_o       = sh;
   assign data_valid_o = valid_q;
   assign match_o      = match_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Directed bench for serial_byte_assembler: an MSB-first default instance and
// an LSB-first instance share the same stimulus.
module tb_serial_byte_assembler;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       bit_i;
   logic       bit_valid_i;
   logic       clear_i;
   logic       data_ready_i;
   logic       bit_ready_o,  lsb_bit_ready_o;
   logic [7:0] data_o,       lsb_data_o;
   logic       data_valid_o, lsb_data_valid_o;
   logic       match_o,      lsb_match_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   serial_byte_assembler u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .bit_ready_o  (bit_ready_o),
      .clear_i      (clear_i),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .match_o      (match_o)
   );

   serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0), .MATCH_PATTERN(8'hAF)) u_lsb (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .bit_ready_o  (lsb_bit_ready_o),
      .clear_i      (clear_i),
      .data_o       (lsb_data_o),
      .data_valid_o (lsb_data_valid_o),
      .data_ready_i (data_ready_i),
      .match_o      (lsb_match_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sends w[7] first; with bubbles, (7-i)%4 idle cycles precede bit i
   task automatic send_word(input logic [7:0] w, input bit bubbles);
      for (int i = 7; i >= 0; i--) begin
         if (bubbles) begin
            repeat ((7 - i) % 4) begin
               @(negedge clk_i);
               bit_valid_i = 1'b0;
               bit_i       = ~w[i];
            end
            check("no_early_valid", 32'(data_valid_o), 0);
         end
         @(negedge clk_i);
         bit_valid_i = 1'b1;
         bit_i       = w[i];
      end
      @(negedge clk_i);
      bit_valid_i = 1'b0;
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         bit_valid_i = 1'b1;
         bit_i       = 1'b1;
      end
      @(negedge clk_i);
      bit_valid_i = 1'b0;
   endtask

   initial begin
      rst_ni       = 1'b0;
      bit_i        = 1'b0;
      bit_valid_i  = 1'b0;
      clear_i      = 1'b0;
      data_ready_i = 1'b1;

      // Reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         bit_i        = i[0];
         bit_valid_i  = 1'b1;
         data_ready_i = i[1];
      end
      check("rst_data",  32'(data_o), 0);
      check("rst_valid", 32'(data_valid_o), 0);
      check("rst_match", 32'(match_o), 0);
      check("rst_ready", 32'(bit_ready_o), 1);
      @(negedge clk_i);
      bit_valid_i  = 1'b0;
      data_ready_i = 1'b1;
      rst_ni       = 1'b1;

      // Pattern match, consecutive bits
      send_word(8'hAF, 1'b0);
      check("pm_data",  32'(data_o), 32'h AF);
      check("pm_valid", 32'(data_valid_o), 1);
      check("pm_match", 32'(match_o), 1);
      check("pm_ready", 32'(bit_ready_o), 0);
      @(negedge clk_i);
      check("pm_valid_drop", 32'(data_valid_o), 0);
      check("pm_match_drop", 32'(match_o), 0);
      check("pm_ready_back", 32'(bit_ready_o), 1);

      // Backpressure: HOLD frozen while bits are offered
      data_ready_i = 1'b0;
      send_word(8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bit_valid_i = 1'b1;
         bit_i       = i[0];
         @(negedge clk_i);
         check("bp_data",  32'(data_o), 32'h3C);
         check("bp_valid", 32'(data_valid_o), 1);
         check("bp_match", 32'(match_o), 0);
         check("bp_ready", 32'(bit_ready_o), 0);
      end
      bit_valid_i  = 1'b0;
      data_ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_release", 32'(data_valid_o), 0);
      // A fresh full word proves no bit was consumed during HOLD
      send_word(8'hC3, 1'b0);
      check("bp_next_data",  32'(data_o), 32'hC3);
      check("bp_next_valid", 32'(data_valid_o), 1);
      @(negedge clk_i);

      // Bubbles between bits
      send_word(8'hAF, 1'b1);
      check("bub_data",  32'(data_o), 32'hAF);
      check("bub_valid", 32'(data_valid_o), 1);
      check("bub_match", 32'(match_o), 1);
      @(negedge clk_i);
      check("bub_valid_drop", 32'(data_valid_o), 0);

      // clear_i mid-word, colliding with a valid bit
      send_ones(5);
      bit_valid_i = 1'b1;
      bit_i       = 1'b1;
      clear_i     = 1'b1;
      @(negedge clk_i);
      clear_i     = 1'b0;
      bit_valid_i = 1'b0;
      check("clr_data",  32'(data_o), 0);
      check("clr_valid", 32'(data_valid_o), 0);
      data_ready_i = 1'b0;
      send_word(8'h55, 1'b0);
      check("clr_word",  32'(data_o), 32'h55);
      check("clr_wvalid", 32'(data_valid_o), 1);
      check("clr_match", 32'(match_o), 0);
      // clear_i during HOLD
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      check("clrh_valid", 32'(data_valid_o), 0);
      check("clrh_data",  32'(data_o), 0);
      check("clrh_ready", 32'(bit_ready_o), 1);
      data_ready_i = 1'b1;

      // Asynchronous reset mid-word
      send_ones(3);
      check("pre_rst_data", 32'(data_o), 32'h07);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_data",  32'(data_o), 0);
      check("arst_valid", 32'(data_valid_o), 0);
      check("arst_match", 32'(match_o), 0);
      check("arst_ready", 32'(bit_ready_o), 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      send_word(8'hC3, 1'b0);
      check("arst_word",  32'(data_o), 32'hC3);
      check("arst_wvalid", 32'(data_valid_o), 1);
      @(negedge clk_i);

      // Bits 1,1,1,1,0,1,0,1 : LSB-first instance assembles 8'hAF
      send_word(8'hF5, 1'b0);
      check("lsb_data",  32'(lsb_data_o), 32'hAF);
      check("lsb_valid", 32'(lsb_data_valid_o), 1);
      check("lsb_match", 32'(lsb_match_o), 1);
      check("msb_same_bits", 32'(data_o), 32'hF5);
      check("msb_no_match",  32'(match_o), 0);
      @(negedge clk_i);
      check("lsb_ready_back", 32'(lsb_bit_ready_o), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
